vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_pkg.sv | 48 ++++
 rtl/vram_slot_sel.sv | 38 +++
 rtl/vram_arbiter.sv | 111 +++++++++++
 tb/tb_vram_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM slot arbiter: owner encoding,
// bus widths and the active-window slot allocation table.
package vram_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_BG   = 2'd1,
    OWN_SP   = 2'd2,
    OWN_CPU  = 2'd3
  } owner_e;

  // Bit positions of each requester in request/acknowledge vectors.
  localparam int REQ_BG  = 0;
  localparam int REQ_SP  = 1;
  localparam int REQ_CPU = 2;

  // Slot owner inside the active window, indexed by HPOS[1:0].
  localparam owner_e SLOT_OWNER_0 = OWN_BG;
  localparam owner_e SLOT_OWNER_1 = OWN_BG;
  localparam owner_e SLOT_OWNER_2 = OWN_SP;
  localparam owner_e SLOT_OWNER_3 = OWN_CPU;

  function automatic owner_e slot_owner(input logic [1:0] phase);
    owner_e res;
    case (phase)
      2'd0:    res = SLOT_OWNER_0;
      2'd1:    res = SLOT_OWNER_1;
      2'd2:    res = SLOT_OWNER_2;
      default: res = SLOT_OWNER_3;
    endcase
    return res;
  endfunction

  function automatic logic [2:0] owner_mask(input owner_e owner);
    logic [2:0] res;
    case (owner)
      OWN_BG:  res = 3'b001;
      OWN_SP:  res = 3'b010;
      OWN_CPU: res = 3'b100;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/vram_slot_sel.sv
// Picks the winner of the next VRAM slot: the table owner inside the active
// window, otherwise (or when the owner is idle) fixed priority CPU > SP > BG.
module vram_slot_sel
  import vram_pkg::*;
(
  input  logic [8:0] hpos,
  input  logic       vblk,
  input  logic [2:0] req,
  input  logic [2:0] excl,
  output owner_e     winner
);

  logic [2:0] elig;
  logic       active;
  owner_e     table_owner;
  logic       unused_hpos_bits;

  // Only the window bit and the slot phase matter for allocation.
  assign unused_hpos_bits = ^hpos[7:2];

  always_comb begin
    elig        = req & ~excl;
    active      = ~vblk & ~hpos[8];
    table_owner = slot_owner(hpos[1:0]);
    if (active && ((elig & owner_mask(table_owner)) != 3'b000)) begin
      winner = table_owner;
    end else if (elig[REQ_CPU]) begin
      winner = OWN_CPU;
    end else if (elig[REQ_SP]) begin
      winner = OWN_SP;
    end else if (elig[REQ_BG]) begin
      winner = OWN_BG;
    end else begin
      winner = OWN_NONE;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Time-slotted arbiter sharing one single-port VRAM between tile fetch,
// sprite fetch and the CPU; grant of slot N+1 overlaps completion of slot N.
module vram_arbiter
  import vram_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PCLK_EN,
  input  logic [8:0]        HPOS,
  input  logic              VBLK,
  input  logic              BG_REQ,
  input  logic [ADDR_W-1:0] BG_AD,
  output logic              BG_ACK,
  output logic [DATA_W-1:0] BG_DT,
  input  logic              SP_REQ,
  input  logic [ADDR_W-1:0] SP_AD,
  output logic              SP_ACK,
  output logic [DATA_W-1:0] SP_DT,
  input  logic              CPU_REQ,
  input  logic              CPU_WR,
  input  logic [ADDR_W-1:0] CPU_AD,
  input  logic [DATA_W-1:0] CPU_DO,
  output logic [DATA_W-1:0] CPU_DI,
  output logic              CPU_WAIT,
  output logic [ADDR_W-1:0] VR_AD,
  output logic              VR_WE,
  output logic [DATA_W-1:0] VR_DO,
  input  logic [DATA_W-1:0] VR_DI
);

  owner_e            owner_q, owner_d, winner;
  logic [ADDR_W-1:0] vr_ad_q, vr_ad_d;
  logic              vr_we_q, vr_we_d;
  logic [DATA_W-1:0] vr_do_q, vr_do_d;
  logic [DATA_W-1:0] bg_dt_q, bg_dt_d;
  logic [DATA_W-1:0] sp_dt_q, sp_dt_d;
  logic [DATA_W-1:0] cpu_di_q, cpu_di_d;
  logic [2:0]        req, ack;

  assign req = {CPU_REQ, SP_REQ, BG_REQ};

  // The access in flight retires on this enabled edge; its requester is
  // kept out of the new grant so it cannot be served twice.
  assign ack = PCLK_EN ? owner_mask(owner_q) : 3'b000;

  vram_slot_sel u_slot_sel (
    .hpos   (HPOS),
    .vblk   (VBLK),
    .req    (req),
    .excl   (ack),
    .winner (winner)
  );

  always_comb begin
    owner_d  = owner_q;
    vr_ad_d  = vr_ad_q;
    vr_we_d  = vr_we_q;
    vr_do_d  = vr_do_q;
    bg_dt_d  = bg_dt_q;
    sp_dt_d  = sp_dt_q;
    cpu_di_d = cpu_di_q;
    if (PCLK_EN) begin
      if (ack[REQ_BG]) bg_dt_d = VR_DI;
      if (ack[REQ_SP]) sp_dt_d = VR_DI;
      if (ack[REQ_CPU] && !vr_we_q) cpu_di_d = VR_DI;
      owner_d = winner;
      vr_we_d = 1'b0;
      case (winner)
        OWN_BG:  vr_ad_d = BG_AD;
        OWN_SP:  vr_ad_d = SP_AD;
        OWN_CPU: begin
          vr_ad_d = CPU_AD;
          vr_we_d = CPU_WR;
          if (CPU_WR) vr_do_d = CPU_DO;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      owner_q  <= OWN_NONE;
      vr_ad_q  <= '0;
      vr_we_q  <= 1'b0;
      vr_do_q  <= '0;
      bg_dt_q  <= '0;
      sp_dt_q  <= '0;
      cpu_di_q <= '0;
    end else begin
      owner_q  <= owner_d;
      vr_ad_q  <= vr_ad_d;
      vr_we_q  <= vr_we_d;
      vr_do_q  <= vr_do_d;
      bg_dt_q  <= bg_dt_d;
      sp_dt_q  <= sp_dt_d;
      cpu_di_q <= cpu_di_d;
    end
  end

  assign BG_ACK   = ack[REQ_BG];
  assign SP_ACK   = ack[REQ_SP];
  assign CPU_WAIT = CPU_REQ & ~ack[REQ_CPU];
  assign BG_DT    = bg_dt_q;
  assign SP_DT    = sp_dt_q;
  assign CPU_DI   = cpu_di_q;
  assign VR_AD    = vr_ad_q;
  assign VR_WE    = vr_we_q;
  assign VR_DO    = vr_do_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed slot-by-slot bench for vram_arbiter with a behavioural VRAM and a
// completion scoreboard holding the expected requester, slot and data.
`timescale 1ns/1ps
module tb_vram_arbiter;
  import vram_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET, PCLK_EN, VBLK;
  logic [8:0]  HPOS;
  logic        BG_REQ, SP_REQ, CPU_REQ, CPU_WR;
  logic [13:0] BG_AD, SP_AD, CPU_AD, VR_AD;
  logic [15:0] CPU_DO, BG_DT, SP_DT, CPU_DI, VR_DO, VR_DI;
  logic        BG_ACK, SP_ACK, CPU_WAIT, VR_WE;
  logic        CPU_ACK_UNUSED;

  typedef struct {
    owner_e      port;
    int          slot;
    logic [15:0] data;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  logic [15:0] vram_mem [0:16383];
  int          tests_run = 0;
  int          fail_count = 0;
  int          slot_num = 0;
  logic [2:0]  ack_seen;
  logic        cpu_wait_seen, cpu_req_seen;
  logic [15:0] exp_bg_dt = 16'h0, exp_sp_dt = 16'h0, exp_cpu_di = 16'h0;
  int          wait_slots;

  vram_arbiter dut (
    .CLK(CLK), .RESET(RESET), .PCLK_EN(PCLK_EN), .HPOS(HPOS), .VBLK(VBLK),
    .BG_REQ(BG_REQ), .BG_AD(BG_AD), .BG_ACK(BG_ACK), .BG_DT(BG_DT),
    .SP_REQ(SP_REQ), .SP_AD(SP_AD), .SP_ACK(SP_ACK), .SP_DT(SP_DT),
    .CPU_REQ(CPU_REQ), .CPU_WR(CPU_WR), .CPU_AD(CPU_AD), .CPU_DO(CPU_DO),
    .CPU_DI(CPU_DI), .CPU_WAIT(CPU_WAIT),
    .VR_AD(VR_AD), .VR_WE(VR_WE), .VR_DO(VR_DO), .VR_DI(VR_DI)
  );

  // CPU acknowledge is not a port; it is seen as CPU_WAIT dropping while CPU_REQ is held.
  assign CPU_ACK_UNUSED = CPU_REQ & ~CPU_WAIT;

  always #5 CLK = ~CLK;

  function automatic logic [15:0] pattern(input logic [13:0] a);
    return ({2'b00, a} * 16'd7) ^ 16'hA5C3;
  endfunction

  // Behavioural VRAM: combinational read, write retired on the enabled edge.
  assign VR_DI = vram_mem[VR_AD];
  always @(posedge CLK) begin
    if (PCLK_EN && VR_WE) vram_mem[VR_AD] <= VR_DO;
  end

  initial begin
    for (int i = 0; i < 16384; i++) vram_mem[i] <= pattern(14'(i));
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at slot %0d",
               tag, observed, expected, slot_num);
    end
  endtask

  task automatic expectDone(input owner_e port, input int slot, input logic [15:0] data);
    sb_entry_t e;
    e.port = port;
    e.slot = slot;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic retireAck(input owner_e port);
    sb_entry_t   e;
    logic [15:0] dt;
    case (port)
      OWN_BG:  dt = BG_DT;
      OWN_SP:  dt = SP_DT;
      default: dt = CPU_DI;
    endcase
    if (sb_q.size() == 0) begin
      checkOutput("unexpected_ack", 32'(port), 32'(OWN_NONE));
    end else begin
      e = sb_q.pop_front();
      checkOutput("ack_port", 32'(port), 32'(e.port));
      checkOutput("ack_slot", slot_num, e.slot);
      checkOutput("ack_data", dt, e.data);
      case (e.port)
        OWN_BG:  exp_bg_dt = e.data;
        OWN_SP:  exp_sp_dt = e.data;
        default: exp_cpu_di = e.data;
      endcase
    end
    case (port)
      OWN_BG:  BG_REQ = 1'b0;
      OWN_SP:  SP_REQ = 1'b0;
      default: CPU_REQ = 1'b0;
    endcase
  endtask

  // One VRAM slot: an enabled cycle followed by one disabled cycle.
  task automatic applyStimulus(input logic [8:0] hpos, input logic vblk);
    @(negedge CLK);
    HPOS = hpos;
    VBLK = vblk;
    PCLK_EN = 1'b1;
    #1;
    ack_seen      = {CPU_REQ & ~CPU_WAIT, SP_ACK, BG_ACK};
    cpu_wait_seen = CPU_WAIT;
    cpu_req_seen  = CPU_REQ;
    @(posedge CLK);
    #1;
    PCLK_EN = 1'b0;
    slot_num++;
    if (ack_seen[REQ_BG])  retireAck(OWN_BG);
    if (ack_seen[REQ_SP])  retireAck(OWN_SP);
    if (ack_seen[REQ_CPU]) retireAck(OWN_CPU);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RESET = 1'b1; PCLK_EN = 1'b1; HPOS = '0; VBLK = 1'b0;
    BG_REQ = 1'b0; SP_REQ = 1'b0; CPU_REQ = 1'b0; CPU_WR = 1'b0;
    BG_AD = '0; SP_AD = '0; CPU_AD = '0; CPU_DO = '0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_vr_ad", VR_AD, 0);
    checkOutput("rst_vr_we", VR_WE, 0);
    checkOutput("rst_vr_do", VR_DO, 0);
    checkOutput("rst_acks", {BG_ACK, SP_ACK}, 0);
    checkOutput("rst_dt", {BG_DT, SP_DT}, 0);
    checkOutput("rst_cpu_di", CPU_DI, 0);
    @(negedge CLK);
    RESET = 1'b0;
    PCLK_EN = 1'b0;

    // Tile fetch in its own slot, granted on the first edge after reset.
    BG_AD = 14'h0123; BG_REQ = 1'b1;
    expectDone(OWN_BG, slot_num + 2, pattern(14'h0123));
    applyStimulus(9'd4, 1'b0);
    checkOutput("bg_grant_ad", VR_AD, 14'h0123);
    checkOutput("bg_grant_we", VR_WE, 0);
    applyStimulus(9'd5, 1'b0);

    // CPU write contending with BG and SP inside the active window.
    applyStimulus(9'd0, 1'b0);
    BG_AD = 14'h0200; BG_REQ = 1'b1;
    SP_AD = 14'h0300; SP_REQ = 1'b1;
    CPU_AD = 14'h3FFF; CPU_DO = 16'hBEEF; CPU_WR = 1'b1; CPU_REQ = 1'b1;
    expectDone(OWN_BG,  slot_num + 2, pattern(14'h0200));
    expectDone(OWN_SP,  slot_num + 3, pattern(14'h0300));
    expectDone(OWN_CPU, slot_num + 4, exp_cpu_di);
    wait_slots = 0;
    for (int h = 1; h <= 3; h++) begin
      applyStimulus(9'(h), 1'b0);
      if (cpu_req_seen) wait_slots++;
      checkOutput("cpu_wait_high", cpu_wait_seen, 1);
    end
    checkOutput("cpu_wr_ad", VR_AD, 14'h3FFF);
    checkOutput("cpu_wr_we", VR_WE, 1);
    checkOutput("cpu_wr_do", VR_DO, 16'hBEEF);
    applyStimulus(9'd4, 1'b0);
    if (cpu_req_seen) wait_slots++;
    checkOutput("cpu_wait_at_ack", cpu_wait_seen, 0);
    checkOutput("cpu_wait_slots", wait_slots, 4);
    checkOutput("cpu_wr_we_clear", VR_WE, 0);

    // CPU read back of the top address in vertical blank.
    CPU_WR = 1'b0; CPU_AD = 14'h3FFF; CPU_REQ = 1'b1;
    expectDone(OWN_CPU, slot_num + 2, 16'hBEEF);
    applyStimulus(9'd0, 1'b1);
    applyStimulus(9'd1, 1'b1);

    // Vertical blank, all three requesting: strict priority order.
    BG_AD = 14'h0010; SP_AD = 14'h0020; CPU_AD = 14'h0030;
    BG_REQ = 1'b1; SP_REQ = 1'b1; CPU_REQ = 1'b1;
    expectDone(OWN_CPU, slot_num + 2, pattern(14'h0030));
    expectDone(OWN_SP,  slot_num + 3, pattern(14'h0020));
    expectDone(OWN_BG,  slot_num + 4, pattern(14'h0010));
    for (int h = 100; h < 104; h++) applyStimulus(9'(h), 1'b1);

    // Idle sprite slot falls back to BG; afterwards nobody owns the slot.
    BG_AD = 14'h0040; BG_REQ = 1'b1;
    expectDone(OWN_BG, slot_num + 2, pattern(14'h0040));
    applyStimulus(9'd2, 1'b0);
    checkOutput("fallback_ad", VR_AD, 14'h0040);
    applyStimulus(9'd3, 1'b0);
    applyStimulus(9'd4, 1'b0);
    checkOutput("none_no_ack", ack_seen, 0);
    checkOutput("none_we", VR_WE, 0);

    // Reset in the middle of a CPU write abandons it; re-grant after release.
    CPU_AD = 14'h1234; CPU_DO = 16'h55AA; CPU_WR = 1'b1; CPU_REQ = 1'b1;
    applyStimulus(9'd0, 1'b1);
    checkOutput("pre_rst_we", VR_WE, 1);
    RESET = 1'b1;
    PCLK_EN = 1'b1;
    #1;
    checkOutput("rst_mid_we", VR_WE, 0);
    checkOutput("rst_mid_cpu_ack", CPU_WAIT, 1);
    checkOutput("rst_mid_bg_dt", BG_DT, 0);
    exp_bg_dt = 16'h0; exp_sp_dt = 16'h0; exp_cpu_di = 16'h0;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    PCLK_EN = 1'b0;
    expectDone(OWN_CPU, slot_num + 2, exp_cpu_di);
    applyStimulus(9'd1, 1'b1);
    checkOutput("regrant_we", VR_WE, 1);
    checkOutput("regrant_ad", VR_AD, 14'h1234);
    applyStimulus(9'd2, 1'b1);
    CPU_WR = 1'b0; CPU_REQ = 1'b1;
    expectDone(OWN_CPU, slot_num + 2, 16'h55AA);
    applyStimulus(9'd3, 1'b1);
    applyStimulus(9'd4, 1'b1);

    // Pixel enable held low mid-access: everything frozen, no completion.
    BG_AD = 14'h0555; BG_REQ = 1'b1;
    expectDone(OWN_BG, slot_num + 2, pattern(14'h0555));
    applyStimulus(9'd8, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK);
      #1;
      checkOutput("hold_ad", VR_AD, 14'h0555);
      checkOutput("hold_ack", BG_ACK, 0);
      checkOutput("hold_dt", BG_DT, exp_bg_dt);
    end
    applyStimulus(9'd9, 1'b0);

    checkOutput("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
